// File: rtl/lsu_pkg.sv
// Shared encodings and access helpers for the load/store unit.
// Size codes, FSM states, alignment and lane-mapping functions.
package lsu_pkg;

    localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
    localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
    localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_REQ      = 2'd1,
        LSU_WAIT_RSP = 2'd2
    } lsu_state_e;

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic bad;
        bad = 1'b1;
        unique case (size)
            LSU_SIZE_BYTE: bad = 1'b0;
            LSU_SIZE_HALF: bad = off[0];
            LSU_SIZE_WORD: bad = |off;
            default:       bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (size)
            LSU_SIZE_BYTE: be = 4'b0001 << off;
            LSU_SIZE_HALF: be = 4'b0011 << off;
            default:       be = 4'b1111;
        endcase
        return be;
    endfunction

    // Narrow stores are replicated so every enabled lane sees the data.
    function automatic logic [31:0] lane_wdata(
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        logic [31:0] wd;
        wd = wdata;
        unique case (size)
            LSU_SIZE_BYTE: wd = {4{wdata[7:0]}};
            LSU_SIZE_HALF: wd = {2{wdata[15:0]}};
            default:       wd = wdata;
        endcase
        return wd;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit and memory.
// master is the LSU side, slave is the memory side.
interface lsu_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  data_req_o;
    logic                  data_gnt_i;
    logic [ADDR_WIDTH-1:0] data_addr_o;
    logic                  data_we_o;
    logic [3:0]            data_be_o;
    logic [31:0]           data_wdata_o;
    logic                  data_rvalid_i;
    logic [31:0]           data_rdata_i;

    modport master (
        output data_req_o, data_addr_o, data_we_o,
        output data_be_o, data_wdata_o,
        input  data_gnt_i, data_rvalid_i, data_rdata_i
    );

    modport slave (
        input  data_req_o, data_addr_o, data_we_o,
        input  data_be_o, data_wdata_o,
        output data_gnt_i, data_rvalid_i, data_rdata_i
    );
endinterface

// File: rtl/lsu_rdata_align.sv
// Load lane select and sign/zero extension of bus read data.
// Purely combinational; offset and size come from the issue latch.
module lsu_rdata_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sext,
    output logic [31:0] data
);
    logic [7:0]  byte_l;
    logic [15:0] half_l;

    assign byte_l = rdata[{off, 3'b000} +: 8];
    assign half_l = rdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        data = rdata;
        unique case (size)
            LSU_SIZE_BYTE: data = {{24{sext & byte_l[7]}}, byte_l};
            LSU_SIZE_HALF: data = {{16{sext & half_l[15]}}, half_l};
            default:       data = rdata;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: alignment check, bus handshake, load extension.
// One outstanding access; IDLE issues combinationally from the inputs.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_en_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_size_i,
    input  logic                  lsu_sign_ext_i,
    input  logic                  kill_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  lsu_err_o,
    output logic                  lsu_done_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  busy_o,
    lsu_if.master                 bus
);
    lsu_state_e            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic                  we_q;
    logic [31:0]           wdata_q;
    logic [1:0]            off_q;
    logic [1:0]            size_q;
    logic                  sext_q;

    logic                  idle;
    logic                  mis;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [31:0]           rd_ext;

    assign idle   = (state_q == LSU_IDLE);
    assign mis    = misaligned(lsu_size_i, addr_i[1:0]);
    assign issue  = idle & ~rst & lsu_en_i & ~mis & ~kill_i;
    assign addr_w = {addr_i[ADDR_WIDTH-1:2], 2'b00};

    assign lsu_err_o  = idle & lsu_en_i & mis;
    assign busy_o     = ~idle;
    assign lsu_done_o = (state_q == LSU_WAIT_RSP) & bus.data_rvalid_i;

    // IDLE presents the live inputs; later states replay the latch.
    always_comb begin
        if (idle) begin
            bus.data_req_o   = issue;
            bus.data_addr_o  = addr_w;
            bus.data_we_o    = lsu_we_i;
            bus.data_be_o    = byte_en(lsu_size_i, addr_i[1:0]);
            bus.data_wdata_o = lane_wdata(lsu_size_i, wdata_i);
        end else begin
            bus.data_req_o   = (state_q == LSU_REQ);
            bus.data_addr_o  = addr_q;
            bus.data_we_o    = we_q;
            bus.data_be_o    = be_q;
            bus.data_wdata_o = wdata_q;
        end
    end

    lsu_rdata_align u_align (
        .rdata (bus.data_rdata_i),
        .off   (off_q),
        .size  (size_q),
        .sext  (sext_q),
        .data  (rd_ext)
    );

    assign lsu_rdata_o = (lsu_done_o & ~we_q) ? rd_ext : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            off_q   <= '0;
            size_q  <= '0;
            sext_q  <= 1'b0;
        end else begin
            unique case (state_q)
                LSU_IDLE: begin
                    if (issue) begin
                        addr_q  <= addr_w;
                        be_q    <= byte_en(lsu_size_i, addr_i[1:0]);
                        we_q    <= lsu_we_i;
                        wdata_q <= lane_wdata(lsu_size_i, wdata_i);
                        off_q   <= addr_i[1:0];
                        size_q  <= lsu_size_i;
                        sext_q  <= lsu_sign_ext_i;
                        state_q <= bus.data_gnt_i ? LSU_WAIT_RSP : LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    if (bus.data_gnt_i) state_q <= LSU_WAIT_RSP;
                end
                LSU_WAIT_RSP: begin
                    if (bus.data_rvalid_i) state_q <= LSU_IDLE;
                end
                default: state_q <= LSU_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu against a behavioural access model.
// Directed cases from the plan plus randomized aligned traffic.
module tb_lsu;
    logic        clk;
    logic        rst;
    logic        lsu_en_i;
    logic        lsu_we_i;
    logic [1:0]  lsu_size_i;
    logic        lsu_sign_ext_i;
    logic        kill_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        lsu_err_o;
    logic        lsu_done_o;
    logic [31:0] lsu_rdata_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    lsu_if #(.ADDR_WIDTH(32)) bus ();

    lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_en_i       (lsu_en_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_sign_ext_i (lsu_sign_ext_i),
        .kill_i         (kill_i),
        .addr_i         (addr_i),
        .wdata_i        (wdata_i),
        .lsu_err_o      (lsu_err_o),
        .lsu_done_o     (lsu_done_o),
        .lsu_rdata_o    (lsu_rdata_o),
        .busy_o         (busy_o),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an access covers 2**size bytes starting at addr.
    function automatic logic [3:0] exp_be(input logic [1:0] size,
                                          input logic [31:0] a);
        int n;
        logic [7:0] m;
        n = 1 << size;
        m = 8'((1 << n) - 1) << a[1:0];
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] size,
                                              input logic [31:0] wd);
        int n;
        logic [31:0] r;
        n = 1 << size;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rdata(input logic we,
                                              input logic [1:0] size,
                                              input logic [31:0] a,
                                              input logic sext,
                                              input logic [31:0] rd);
        int n;
        logic [31:0] v, mask;
        if (we) return 32'h0;
        n = 1 << size;
        v = rd >> (8 * int'(a[1:0]));
        mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
        v = v & mask;
        if (sext && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic do_access(input string nm, input logic we,
                             input logic [1:0] size, input logic [31:0] a,
                             input logic [31:0] wd, input logic sext,
                             input int gd, input int rdly,
                             input logic [31:0] rdat);
        logic [31:0] aw_e, wd_e, rd_e;
        logic [3:0]  be_e;
        aw_e = {a[31:2], 2'b00};
        be_e = exp_be(size, a);
        wd_e = exp_wdata(size, wd);
        rd_e = exp_rdata(we, size, a, sext, rdat);
        @(negedge clk);
        lsu_en_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
        lsu_sign_ext_i = sext; kill_i = 1'b0; addr_i = a; wdata_i = wd;
        bus.data_gnt_i = (gd == 0); bus.data_rvalid_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL %s issue busy got %b exp 0", nm, busy_o);
        end
        checks++;
        if (bus.data_req_o !== 1'b1 || lsu_err_o !== 1'b0) begin
            errors++;
            $display("FAIL %s issue req/err got %b/%b exp 1/0",
                     nm, bus.data_req_o, lsu_err_o);
        end
        checks++;
        if (bus.data_addr_o !== aw_e || bus.data_be_o !== be_e ||
            bus.data_we_o !== we || bus.data_wdata_o !== wd_e) begin
            errors++;
            $display("FAIL %s issue bus got %h/%b/%b/%h exp %h/%b/%b/%h", nm,
                     bus.data_addr_o, bus.data_be_o, bus.data_we_o,
                     bus.data_wdata_o, aw_e, be_e, we, wd_e);
        end
        @(posedge clk);
        for (int i = 1; i <= gd; i++) begin
            @(negedge clk);
            lsu_en_i = 1'($urandom); lsu_we_i = 1'($urandom);
            lsu_size_i = 2'($urandom); addr_i = $urandom; wdata_i = $urandom;
            bus.data_gnt_i = (i == gd);
            #1;
            checks++;
            if (bus.data_req_o !== 1'b1 || busy_o !== 1'b1 ||
                lsu_err_o !== 1'b0) begin
                errors++;
                $display("FAIL %s stall%0d req/busy/err got %b/%b/%b exp 1/1/0",
                         nm, i, bus.data_req_o, busy_o, lsu_err_o);
            end
            checks++;
            if (bus.data_addr_o !== aw_e || bus.data_be_o !== be_e ||
                bus.data_we_o !== we || bus.data_wdata_o !== wd_e) begin
                errors++;
                $display("FAIL %s stall%0d bus got %h/%b/%b/%h exp %h/%b/%b/%h",
                         nm, i, bus.data_addr_o, bus.data_be_o, bus.data_we_o,
                         bus.data_wdata_o, aw_e, be_e, we, wd_e);
            end
            @(posedge clk);
        end
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            lsu_en_i = 1'($urandom); lsu_size_i = 2'($urandom);
            addr_i = $urandom; bus.data_gnt_i = 1'b0;
            #1;
            checks++;
            if (bus.data_req_o !== 1'b0 || lsu_done_o !== 1'b0 ||
                lsu_err_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL %s wait%0d req/done/err/busy got %b/%b/%b/%b exp 0/0/0/1",
                         nm, i, bus.data_req_o, lsu_done_o, lsu_err_o, busy_o);
            end
            @(posedge clk);
        end
        @(negedge clk);
        lsu_en_i = 1'($urandom); addr_i = $urandom;
        bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b1;
        bus.data_rdata_i = rdat;
        #1;
        checks++;
        if (lsu_done_o !== 1'b1 || bus.data_req_o !== 1'b0) begin
            errors++;
            $display("FAIL %s done/req got %b/%b exp 1/0",
                     nm, lsu_done_o, bus.data_req_o);
        end
        checks++;
        if (lsu_rdata_o !== rd_e) begin
            errors++;
            $display("FAIL %s rdata got %h exp %h", nm, lsu_rdata_o, rd_e);
        end
        @(posedge clk);
        @(negedge clk);
        lsu_en_i = 1'b0; bus.data_rvalid_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b0 || lsu_done_o !== 1'b0) begin
            errors++;
            $display("FAIL %s after busy/done got %b/%b exp 0/0",
                     nm, busy_o, lsu_done_o);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        lsu_en_i = 1'b1; lsu_size_i = 2'b10; addr_i = 32'h102;
        #1;
        checks++;
        if (lsu_err_o !== 1'b1 || bus.data_req_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mis err/req got %b/%b exp 1/0",
                     lsu_err_o, bus.data_req_o);
        end
        addr_i = 32'h100;
        #1;
        checks++;
        if (bus.data_req_o !== 1'b0 || busy_o !== 1'b0 ||
            lsu_done_o !== 1'b0 || lsu_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state req/busy/done/err got %b/%b/%b/%b exp 0/0/0/0",
                     bus.data_req_o, busy_o, lsu_done_o, lsu_err_o);
        end
        lsu_en_i = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic [31:0] ad [4] = '{32'h102, 32'h101, 32'h100, 32'h103};
        logic        kl [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            lsu_en_i = 1'b1; lsu_we_i = 1'($urandom);
            lsu_size_i = sz[i]; addr_i = ad[i]; kill_i = kl[i];
            bus.data_gnt_i = 1'b1;
            #1;
            checks++;
            if (lsu_err_o !== 1'b1 || bus.data_req_o !== 1'b0) begin
                errors++;
                $display("FAIL mis%0d err/req got %b/%b exp 1/0",
                         i, lsu_err_o, bus.data_req_o);
            end
            @(posedge clk);
            @(negedge clk);
            lsu_en_i = 1'b0; kill_i = 1'b0; bus.data_gnt_i = 1'b0;
            #1;
            checks++;
            if (busy_o !== 1'b0 || lsu_err_o !== 1'b0) begin
                errors++;
                $display("FAIL mis%0d after busy/err got %b/%b exp 0/0",
                         i, busy_o, lsu_err_o);
            end
        end
    endtask

    task automatic test_kill();
        @(negedge clk);
        lsu_en_i = 1'b1; kill_i = 1'b1; lsu_we_i = 1'b0;
        lsu_size_i = 2'b10; addr_i = 32'h300; bus.data_gnt_i = 1'b1;
        #1;
        checks++;
        if (bus.data_req_o !== 1'b0 || lsu_err_o !== 1'b0) begin
            errors++;
            $display("FAIL kill req/err got %b/%b exp 0/0",
                     bus.data_req_o, lsu_err_o);
        end
        @(posedge clk);
        @(negedge clk);
        lsu_en_i = 1'b0; kill_i = 1'b0; bus.data_gnt_i = 1'b0;
        bus.data_rvalid_i = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || lsu_done_o !== 1'b0) begin
            errors++;
            $display("FAIL kill after busy/done got %b/%b exp 0/0",
                     busy_o, lsu_done_o);
        end
        bus.data_rvalid_i = 1'b0;
        do_access("kill_reissue", 1'b0, 2'b10, 32'h300, 32'h0, 1'b0,
                  0, 0, 32'h1234_5678);
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        lsu_en_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = 2'b10;
        addr_i = 32'h400; kill_i = 1'b0; bus.data_gnt_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lsu_en_i = 1'b0; bus.data_gnt_i = 1'b0;
        #1;
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL rst_mid pre busy got %b exp 1", busy_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy_o !== 1'b0 || bus.data_req_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid busy/req got %b/%b exp 0/0",
                     busy_o, bus.data_req_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; bus.data_rvalid_i = 1'b1; bus.data_rdata_i = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (lsu_done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid late rsp done/busy got %b/%b exp 0/0",
                     lsu_done_o, busy_o);
        end
        @(posedge clk);
        @(negedge clk);
        bus.data_rvalid_i = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom & ~((32'd1 << sz) - 32'd1);
            do_access($sformatf("rnd%0d", i), 1'($urandom), sz, a, $urandom,
                      1'($urandom), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom);
        end
    endtask

    initial begin
        rst = 1'b1;
        lsu_en_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'b00;
        lsu_sign_ext_i = 1'b0; kill_i = 1'b0; addr_i = '0; wdata_i = '0;
        bus.data_gnt_i = 1'b0; bus.data_rvalid_i = 1'b0;
        bus.data_rdata_i = '0;
        test_reset();
        do_access("lw", 1'b0, 2'b10, 32'h100, 32'h0, 1'b0,
                  0, 0, 32'hDEAD_BEEF);
        do_access("lb", 1'b0, 2'b00, 32'h103, 32'h0, 1'b1,
                  0, 0, 32'h8012_3456);
        do_access("lbu", 1'b0, 2'b00, 32'h103, 32'h0, 1'b0,
                  0, 1, 32'h8012_3456);
        do_access("sh", 1'b1, 2'b01, 32'h202, 32'h0000_ABCD, 1'b0,
                  3, 0, 32'h5555_5555);
        do_access("lh", 1'b0, 2'b01, 32'h202, 32'h0, 1'b1,
                  1, 2, 32'h8001_7FFF);
        test_misaligned();
        test_kill();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
